sram_spi_cmd_engine: RTL and testbench
======================================

Name: sram_spi_cmd_engine

Overview:
- Bit-level SPI master for the logic-analyzer SRAM chips; sits directly downstream of the MC-bus register decode.
- Consumes the 16-bit command words written to the SRAM debug register (address 0x07) and drives sram_clock, sram_cs and sio0/sio1 in single-bit SPI mode.
- Returns the received byte for MC readback.
- Top muxes its SRAM pin outputs against the quad-mode LA capture path.

Parameters:
- LA_CHIPS, 2, number of SRAM chips; width of sram_clock/sram_cs and of the CS field.
- CMD_WIDTH, 16, command word width.
- CLK_DIV, 2, system clocks per SPI half-period; legal range ≥1.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_data  in  CMD_WIDTH  command word from MC register 0x07.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept; high only in IDLE.
- rsp_data  out  8  received bits, right-justified; holds until next shift response.
- rsp_valid  out  1  one-cycle pulse when a shift command completes.
- busy  out  1  high in any state other than IDLE.
- sram_clock  out  LA_CHIPS  SPI clock, same value on every bit; idles low (mode 0).
- sram_cs  out  LA_CHIPS  active-low chip selects.
- sram_mosi  out  1  drives sio0.
- sram_miso  in  1  sampled from sio1.
- sram_sio_oe  out  1  enables the sio0 driver; high while any sram_cs bit is low.

Behaviour:
- Reset, asynchronous and immediate, including mid-transfer:
  - sram_cs all 1; sram_clock 0; sram_mosi 0; sram_sio_oe 0.
  - rsp_data 0x00; rsp_valid 0; busy 0; cmd_ready 1; state IDLE; divider cleared.
- Handshake: command accepted on a rising edge with cmd_valid & cmd_ready. cmd_valid while busy is ignored; the command is not queued and must be held by the source.
- Command decode:
  - bit15=1, CS command: sram_cs <= cmd_data[LA_CHIPS-1:0] on the accept edge. No clocks, no rsp_valid. Stays in IDLE, so cmd_ready remains 1. Bits 14..LA_CHIPS are ignored.
  - bit15=0, shift command: nbits = cmd_data[11:8], values >8 clamp to 8. tx = cmd_data[7:0]; bit nbits-1 is sent first (MSB-first within the field). Bits 14..12 are ignored.
  - nbits=0: no clocks. rsp_data <= 0x00 and rsp_valid pulses the cycle after accept.
- State machine IDLE -> LOW -> HIGH -> (LOW | DONE) -> IDLE:
  - IDLE: on shift accept, load tx shift register and bit counter, set sram_mosi to the first bit, go to LOW.
  - LOW: sram_clock 0 for CLK_DIV cycles, then HIGH.
  - HIGH: sram_clock 1 for CLK_DIV cycles. sram_miso is sampled into the rx shift register on entry (the clock rising edge).
  - At the end of HIGH, the counter decrements. If bits remain, sram_mosi advances to the next bit (falling edge) and the state returns to LOW. Otherwise it goes to DONE.
  - DONE: rsp_data <= rx (low nbits, upper bits 0); rsp_valid 1 for this cycle; sram_clock 0; next state IDLE.
- Latency: accept to rsp_valid = 2*nbits*CLK_DIV + 1 cycles. cmd_ready returns 1 the cycle after DONE.
- Shift commands do not alter sram_cs; the host frames transfers with CS commands. A shift with all CS high still clocks the bus.
- sram_sio_oe is registered from the sram_cs next-value.
- Divider counter width is clog2(CLK_DIV)+1. CLK_DIV=1 gives one cycle per phase.

Decomposition:
- Package bp_sram_pkg holds:
  - CMD_CS_BIT=15, CMD_NBITS_MSB/LSB=11/8, CMD_DATA_MSB/LSB=7/0.
  - MAX_BITS=8.
  - state enum IDLE/LOW/HIGH/DONE.
- One sub-module, spi_tick_gen: parameter CLK_DIV. Outputs a phase-end tick; cleared on reset and on each accept.

Test Plan:
- Reset, no stimulus -> sram_cs=2'b11, sram_clock=2'b00, sram_mosi=0, sram_sio_oe=0, cmd_ready=1, rsp_valid never asserts.
- cmd 0x8000 -> sram_cs=2'b00 and sram_sio_oe=1 one cycle after accept, no clock edges. Then cmd 0x8001 -> sram_cs=2'b01, sram_sio_oe stays 1.
- CS low, cmd 0x08AA with sram_miso looped to sram_mosi, CLK_DIV=2 -> 8 rising edges, mosi pattern 1,0,1,0,1,0,1,0; rsp_data=0xAA with rsp_valid one pulse 33 cycles after accept.
- cmd 0x0405 with sram_miso tied 1 -> 4 clocks, mosi 0,1,0,1; rsp_data=0x0F. Then cmd 0x0F00 clamps to 8 clocks with mosi all 0; rsp_data=0xFF.
- cmd 0x0000 -> no clocks, rsp_data=0x00, rsp_valid the cycle after accept. Second cmd 0x08FF asserted during a busy transfer -> held off (cmd_ready=0) and accepted only the cycle after the first rsp_valid.
- Reset pulsed low after the 3rd rising edge of 0x08FF -> same cycle: sram_clock=0, sram_cs=2'b11, busy=0, rsp_valid stays 0. Subsequent 0x0855 completes normally with rsp_data = looped 0x55.

Source files
------------

// File: rtl/sram_spi_cmd_engine_pkg.sv
// rtl/sram_spi_cmd_engine_pkg.sv - command field layout, FSM states and decode helpers
package bp_sram_pkg;

  localparam int CMD_CS_BIT    = 15;
  localparam int CMD_NBITS_MSB = 11;
  localparam int CMD_NBITS_LSB = 8;
  localparam int CMD_DATA_MSB  = 7;
  localparam int CMD_DATA_LSB  = 0;
  localparam int MAX_BITS      = 8;
  localparam int NBITS_W       = CMD_NBITS_MSB - CMD_NBITS_LSB + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic [NBITS_W-1:0] clamp_nbits(input logic [NBITS_W-1:0] field);
    return (field > NBITS_W'(MAX_BITS)) ? NBITS_W'(MAX_BITS) : field;
  endfunction

  // Moves bit n-1 of the tx field to the MSB so the shifter always sends from bit 7.
  function automatic logic [MAX_BITS-1:0] align_tx(input logic [MAX_BITS-1:0] tx,
                                                   input logic [NBITS_W-1:0]  n);
    return tx << (NBITS_W'(MAX_BITS) - n);
  endfunction

endpackage

// File: rtl/sram_spi_cmd_engine_if.sv
// rtl/sram_spi_cmd_engine_if.sv - command/response handshake between register decode and SPI engine
interface sram_spi_cmd_engine_if #(
  parameter int CMD_WIDTH = 16
);
  logic [CMD_WIDTH-1:0] cmd_data;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [7:0]           rsp_data;
  logic                 rsp_valid;

  modport master (
    output cmd_data,
    output cmd_valid,
    input  cmd_ready,
    input  rsp_data,
    input  rsp_valid
  );

  modport slave (
    input  cmd_data,
    input  cmd_valid,
    output cmd_ready,
    output rsp_data,
    output rsp_valid
  );
endinterface

// File: rtl/sram_spi_cmd_engine_spi_tick_gen.sv
// rtl/sram_spi_cmd_engine_spi_tick_gen.sv - SPI half-period divider, restarted on every shift accept
module spi_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  output logic tick_o
);

  localparam int CNT_W = $clog2(CLK_DIV) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_spi_cmd_engine.sv
// rtl/sram_spi_cmd_engine.sv - single-bit SPI master for LA SRAM chips driven by 16-bit debug commands
module sram_spi_cmd_engine
  import bp_sram_pkg::*;
#(
  parameter int LA_CHIPS  = 2,
  parameter int CMD_WIDTH = 16,
  parameter int CLK_DIV   = 2
) (
  input  logic                clock,
  input  logic                reset,
  sram_spi_cmd_engine_if.slave cmd_bus,
  output logic                busy,
  output logic [LA_CHIPS-1:0] sram_clock,
  output logic [LA_CHIPS-1:0] sram_cs,
  output logic                sram_mosi,
  input  logic                sram_miso,
  output logic                sram_sio_oe
);

  state_e                state_q;
  logic [LA_CHIPS-1:0]   cs_q;
  logic [LA_CHIPS-1:0]   cs_d;
  logic                  sclk_q;
  logic                  mosi_q;
  logic                  sio_oe_q;
  logic                  rsp_valid_q;
  logic                  cmd_ready_q;
  logic                  busy_q;
  logic [MAX_BITS-1:0]   tx_q;
  logic [MAX_BITS-1:0]   rx_q;
  logic [MAX_BITS-1:0]   rsp_data_q;
  logic [NBITS_W-1:0]    bits_q;

  logic [CMD_WIDTH-1:0]  cmd_word;
  logic                  accept;
  logic                  shift_accept;
  logic                  tick;
  logic [NBITS_W-1:0]    nbits;
  logic [MAX_BITS-1:0]   tx_aligned;
  logic                  unused_cmd_bits;

  assign cmd_word        = cmd_bus.cmd_data;
  assign unused_cmd_bits = ^cmd_word[CMD_CS_BIT-1:CMD_NBITS_MSB+1];

  assign accept       = cmd_bus.cmd_valid & cmd_ready_q;
  assign shift_accept = accept & ~cmd_word[CMD_CS_BIT];
  assign nbits        = clamp_nbits(cmd_word[CMD_NBITS_MSB:CMD_NBITS_LSB]);
  assign tx_aligned   = align_tx(cmd_word[CMD_DATA_MSB:CMD_DATA_LSB], nbits);

  spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clock   (clock),
    .reset   (reset),
    .clear_i (shift_accept),
    .tick_o  (tick)
  );

  // CS commands are only accepted in IDLE, so they never disturb a running shift.
  always_comb begin
    cs_d = cs_q;
    if (accept && cmd_word[CMD_CS_BIT]) begin
      cs_d = cmd_word[LA_CHIPS-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cs_q        <= '1;
      sio_oe_q    <= 1'b0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      bits_q      <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      cs_q        <= cs_d;
      sio_oe_q    <= ~&cs_d;
      case (state_q)
        IDLE: begin
          if (shift_accept) begin
            tx_q        <= tx_aligned;
            mosi_q      <= tx_aligned[MAX_BITS-1];
            rx_q        <= '0;
            bits_q      <= nbits;
            sclk_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= (nbits == '0) ? DONE : LOW;
          end
        end
        LOW: begin
          // Sample on the same edge that raises the SPI clock.
          if (tick) begin
            sclk_q  <= 1'b1;
            rx_q    <= {rx_q[MAX_BITS-2:0], sram_miso};
            state_q <= HIGH;
          end
        end
        HIGH: begin
          if (tick) begin
            sclk_q <= 1'b0;
            bits_q <= bits_q - NBITS_W'(1);
            if (bits_q > NBITS_W'(1)) begin
              tx_q    <= tx_q << 1;
              mosi_q  <= tx_q[MAX_BITS-2];
              state_q <= LOW;
            end else begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          rsp_data_q  <= rx_q;
          rsp_valid_q <= 1'b1;
          sclk_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_bus.cmd_ready = cmd_ready_q;
  assign cmd_bus.rsp_data  = rsp_data_q;
  assign cmd_bus.rsp_valid = rsp_valid_q;
  assign busy              = busy_q;
  assign sram_clock        = {LA_CHIPS{sclk_q}};
  assign sram_cs           = cs_q;
  assign sram_mosi         = mosi_q;
  assign sram_sio_oe       = sio_oe_q;

endmodule

// File: tb/tb_sram_spi_cmd_engine.sv
// tb/tb_sram_spi_cmd_engine.sv - scoreboard bench with random commands against a bit-level SPI model
module tb_sram_spi_cmd_engine;

  localparam int D = 2;

  typedef struct {
    logic [7:0] data;
    int         due;
  } rsp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       busy;
  logic [1:0] sram_clock;
  logic [1:0] sram_cs;
  logic       sram_mosi;
  logic       sram_miso;
  logic       sram_sio_oe;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rise_cnt = 0;
  int   miso_mode = 0;   // 0: looped to mosi, 1: tied high, 2: tied low
  logic prev_clk = 1'b0;

  rsp_t exp_rsp[$];
  logic exp_bits[$];
  rsp_t r;

  sram_spi_cmd_engine_if #(.CMD_WIDTH(16)) bus();

  sram_spi_cmd_engine #(
    .LA_CHIPS  (2),
    .CMD_WIDTH (16),
    .CLK_DIV   (D)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_bus     (bus.slave),
    .busy        (busy),
    .sram_clock  (sram_clock),
    .sram_cs     (sram_cs),
    .sram_mosi   (sram_mosi),
    .sram_miso   (sram_miso),
    .sram_sio_oe (sram_sio_oe)
  );

  assign sram_miso = (miso_mode == 0) ? sram_mosi : (miso_mode == 1);

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: responses against the scoreboard, SPI rising edges against expected mosi bits.
  always @(negedge clock) begin
    if (reset && bus.rsp_valid) begin
      if (exp_rsp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp act=0x%0h exp=none t=%0t", bus.rsp_data, $time);
      end else begin
        r = exp_rsp.pop_front();
        chk("rsp_data", int'(bus.rsp_data), int'(r.data));
        chk("rsp_latency", cyc, r.due);
      end
    end
    if (sram_clock[0] && !prev_clk) begin
      rise_cnt++;
      if (exp_bits.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sclk_rise act=rise exp=none t=%0t", $time);
      end else begin
        chk("mosi_bit", int'(sram_mosi), int'(exp_bits.pop_front()));
      end
    end
    if (sram_clock[1] != sram_clock[0]) begin
      checks++;
      errors++;
      $display("FAIL sclk_lanes act=%b exp=equal t=%0t", sram_clock, $time);
    end
    prev_clk = sram_clock[0];
  end

  task automatic tick1();
    @(negedge clock);
    #1;
  endtask

  // Drives one command, pushes the model's expectations, returns the accept edge index.
  task automatic issue(input logic [15:0] cmd, output int acc);
    int         waitc;
    int         n;
    int         mask;
    logic [7:0] tx;
    logic [7:0] rxv;
    rsp_t       e;
    waitc = 0;
    acc   = -1;
    bus.cmd_data  = cmd;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && waitc < 400) begin
      tick1();
      waitc++;
    end
    if (!bus.cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout act=not_ready exp=ready cmd=0x%0h", cmd);
      bus.cmd_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    if (!cmd[15]) begin
      n = int'(cmd[11:8]);
      if (n > 8) n = 8;
      tx   = cmd[7:0];
      mask = (1 << n) - 1;
      for (int b = n - 1; b >= 0; b--) exp_bits.push_back(tx[b]);
      case (miso_mode)
        0:       rxv = 8'(int'(tx) & mask);
        1:       rxv = 8'(mask);
        default: rxv = 8'h00;
      endcase
      e.data = rxv;
      e.due  = acc + 2 * n * D + 1;
      exp_rsp.push_back(e);
    end
    tick1();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((busy || exp_rsp.size() != 0) && guard < 600) begin
      tick1();
      guard++;
    end
    tick1();
    chk("idle_reached", int'(busy) + exp_rsp.size(), 0);
    chk("bits_left", exp_bits.size(), 0);
    exp_bits.delete();
    exp_rsp.delete();
  endtask

  int         acc1;
  int         acc2;
  int         base;
  int         guard;
  int         kind;
  int         m;
  logic [15:0] c;
  logic [1:0]  exp_cs;

  initial begin
    bus.cmd_data  = '0;
    bus.cmd_valid = 1'b0;
    repeat (3) tick1();
    reset = 1'b1;
    tick1();

    chk("rst_cs", int'(sram_cs), 3);
    chk("rst_sclk", int'(sram_clock), 0);
    chk("rst_mosi", int'(sram_mosi), 0);
    chk("rst_oe", int'(sram_sio_oe), 0);
    chk("rst_ready", int'(bus.cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rsp_data", int'(bus.rsp_data), 0);
    repeat (5) tick1();

    issue(16'h8000, acc1);
    chk("cs_0000", int'(sram_cs), 0);
    chk("oe_after_cs0", int'(sram_sio_oe), 1);
    chk("ready_after_cs", int'(bus.cmd_ready), 1);
    issue(16'h8001, acc1);
    chk("cs_0001", int'(sram_cs), 1);
    chk("oe_after_cs1", int'(sram_sio_oe), 1);
    repeat (3) tick1();

    miso_mode = 0;
    issue(16'h08AA, acc1);
    chk("busy_in_shift", int'(busy), 1);
    chk("ready_in_shift", int'(bus.cmd_ready), 0);
    wait_idle();
    chk("rsp_hold_AA", int'(bus.rsp_data), 8'hAA);

    miso_mode = 1;
    issue(16'h0405, acc1);
    wait_idle();
    issue(16'h0F00, acc1);
    wait_idle();

    miso_mode = 0;
    base = rise_cnt;
    issue(16'h0000, acc1);
    chk("held_off_ready", int'(bus.cmd_ready), 0);
    issue(16'h08FF, acc2);
    chk("holdoff_accept_gap", acc2 - acc1, 2);

    guard = 0;
    while (rise_cnt < base + 3 && guard < 200) begin
      tick1();
      guard++;
    end
    chk("third_rise_seen", rise_cnt - base, 3);
    reset = 1'b0;
    #1;
    exp_bits.delete();
    exp_rsp.delete();
    chk("arst_sclk", int'(sram_clock), 0);
    chk("arst_cs", int'(sram_cs), 3);
    chk("arst_busy", int'(busy), 0);
    chk("arst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("arst_oe", int'(sram_sio_oe), 0);
    repeat (2) tick1();
    reset = 1'b1;
    repeat (2) tick1();
    issue(16'h0855, acc1);
    wait_idle();

    exp_cs = sram_cs;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 4);
      if (kind == 0) begin
        c = 16'h8000 | 16'($urandom & 32'h7FFF);
        issue(c, acc1);
        exp_cs = c[1:0];
        chk("rand_cs", int'(sram_cs), int'(exp_cs));
        chk("rand_oe", int'(sram_sio_oe), int'(exp_cs != 2'b11));
      end else begin
        m = $urandom_range(0, 2);
        if (m != miso_mode) begin
          wait_idle();
          miso_mode = m;
        end
        c = {1'b0, 3'($urandom), 4'($urandom), 8'($urandom)};
        issue(c, acc1);
      end
    end
    wait_idle();
    chk("rand_cs_final", int'(sram_cs), int'(exp_cs));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
